board_state_ctrl: RTL and testbench
===================================

Name: board_state_ctrl

Overview:
- Receiving end of the PicoBlaze board-update registers (locX_state, locY_state, update_state, wea_state_ram).
- Holds the 8x8 checkers board as a register array and applies single-square writes and whole-board clear/init commands issued by firmware.
- Gives the display subsystem a registered read port and maintains per-colour piece counts for the game logic and LEDs.

Parameters:
BOARD_DIM, 8, squares per side; fixed at 8, index width 3
INIT_ROWS, 3, rows per side filled by the INIT command
CNT_W, 7, width of piece counters (max 64)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
locX_state  input  8  target column from the PB interface; valid range 0..7
locY_state  input  8  target row from the PB interface; valid range 0..7
update_state  input  8  command/state code
wea_state_ram  input  1  write request level; the rising edge is the command strobe
rd_x  input  3  display read column
rd_y  input  3  display read row
rd_state  output  3  square code at (rd_x, rd_y); 1-cycle latency
busy  output  1  high while a CLEAR or INIT sweep runs
done  output  1  1-cycle pulse when a command completes
cmd_err  output  1  1-cycle pulse when a command is rejected
red_count  output  CNT_W  red pieces on board (men + kings)
black_count  output  CNT_W  black pieces on board (men + kings)

Behaviour:
- Square codes (3 bits): 0 EMPTY, 1 RED_MAN, 2 BLACK_MAN, 3 RED_KING, 4 BLACK_KING.
- update_state decode:
  - 0x00..0x04: write that code to square (X,Y).
  - 0xFF: CLEAR the whole board.
  - 0xFE: INIT the starting position.
  - Any other value: rejected.
- Reset (asynchronous):
  - All 64 cells = EMPTY; FSM = IDLE.
  - rd_state=0, busy=0, done=0, cmd_err=0, red_count=0, black_count=0.
  - Strobe-edge register wea_q resets to 1, so a level already high at reset release is not a command.
- Strobe detection: strobe = wea_state_ram & ~wea_q; wea_q is updated every cycle.
- FSM states: IDLE, CLEAR, INIT.
- IDLE with strobe, single-square write:
  - If X>7, Y>7 or the code is invalid: no write, cmd_err pulses in the next cycle.
  - Otherwise the cell is updated at the next clock edge and done pulses in that same cycle (latency 1).
  - Counts are updated in the same cycle: decrement the old cell's colour counter if non-empty, increment the new code's colour counter if non-empty. Overwriting with the same code leaves the counts unchanged.
- IDLE with 0xFF strobe:
  - Go to CLEAR; busy=1 from the next cycle.
  - Sweep index i=0..63, one cell per cycle, where cell index = Y*8+X; each cell written EMPTY.
  - Counters are zeroed on the first sweep cycle.
  - After i=63 is written: return to IDLE, busy=0, done pulses. Total 64 cycles busy.
- IDLE with 0xFE strobe:
  - Go to INIT; 64-cycle sweep, same as CLEAR.
  - Cell value: if (X+Y) odd and Y<INIT_ROWS then BLACK_MAN; if (X+Y) odd and Y>=8-INIT_ROWS then RED_MAN; else EMPTY.
  - Counters are zeroed on the first cycle and incremented per placed piece, ending at 12/12.
  - done pulses at the end of the sweep.
- Strobe while busy: the command is dropped, cmd_err pulses, and the sweep continues unaffected.
- Read port: rd_state <= cell[rd_y*8+rd_x] every cycle, in any state. A same-cycle write to the same cell returns the old value (read-before-write).
- Counters: saturate at 0 on decrement and at 64 on increment. Neither condition is reachable with legal commands; saturation is defensive only.
- done and cmd_err are mutually exclusive in any cycle.
- Reset mid-sweep aborts immediately to the reset state; no partial completion pulse.

Decomposition:
- Shared package: square code constants, command constants (CMD_CLEAR=0xFF, CMD_INIT=0xFE), BOARD_DIM, INIT_ROWS.
- One natural sub-module: board_init_rom, a combinational function of (x,y) returning the initial square code. It is reused by the display's "reset view" if needed.
- Sweep counter and FSM stay in the top module.

Test Plan:
- Reset release with wea_state_ram held high -> no done, no write. Then drop and raise wea -> exactly one command executes.
- X=2, Y=5, code 0x01 strobe -> done pulses 1 cycle later, red_count=1. Read (2,5) -> rd_state=1 one cycle after the address is applied.
- Same square rewritten with 0x04 -> red_count=0, black_count=1. Then code 0x00 -> both counts 0.
- 0xFE strobe -> busy high for 64 cycles then done, red_count=12, black_count=12. Read (1,0)=2, (0,0)=0, (0,7)=1, (3,4)=0.
- During INIT, strobe X=0,Y=0 code 1 -> cmd_err pulse, sweep completes with counts 12/12. 0xFF then -> counts 0, all cells EMPTY after 64 cycles.
- X=8 strobe; code 0x07 strobe; reset asserted at sweep cycle 30 -> cmd_err pulses for the first two, board unchanged by them; reset -> counts 0, busy 0, no done.

Source files
------------

// File: rtl/board_state_ctrl_pkg.sv
// rtl/board_state_ctrl_pkg.sv - shared constants, state type and counter helpers for the board state block
package board_state_ctrl_pkg;

  localparam int BOARD_DIM = 8;
  localparam int CELLS     = BOARD_DIM * BOARD_DIM;
  localparam int INIT_ROWS = 3;
  localparam int CNT_W     = 7;

  localparam logic [CNT_W-1:0] CNT_MAX = 7'd64;

  localparam logic [2:0] SQ_EMPTY      = 3'd0;
  localparam logic [2:0] SQ_RED_MAN    = 3'd1;
  localparam logic [2:0] SQ_BLACK_MAN  = 3'd2;
  localparam logic [2:0] SQ_RED_KING   = 3'd3;
  localparam logic [2:0] SQ_BLACK_KING = 3'd4;

  localparam logic [7:0] CMD_MAX_CODE = 8'h04;
  localparam logic [7:0] CMD_INIT     = 8'hFE;
  localparam logic [7:0] CMD_CLEAR    = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_INIT  = 2'd2
  } state_t;

  function automatic logic is_red(input logic [2:0] code);
    return (code == SQ_RED_MAN) || (code == SQ_RED_KING);
  endfunction

  function automatic logic is_black(input logic [2:0] code);
    return (code == SQ_BLACK_MAN) || (code == SQ_BLACK_KING);
  endfunction

  // One counter step; a matching inc/dec pair cancels, both ends saturate.
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                                input logic dec, input logic inc);
    if (inc && !dec) begin
      return (cnt >= CNT_MAX) ? CNT_MAX : cnt + 7'd1;
    end else if (dec && !inc) begin
      return (cnt == 7'd0) ? 7'd0 : cnt - 7'd1;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/board_init_rom.sv
// rtl/board_init_rom.sv - starting-position square code as a function of (x, y)
module board_init_rom
  import board_state_ctrl_pkg::*;
#(
  parameter int ROWS = INIT_ROWS
) (
  input  logic [2:0] x,
  input  logic [2:0] y,
  output logic [2:0] code
);

  localparam logic [2:0] BLACK_LIMIT = 3'(ROWS);
  localparam logic [2:0] RED_FIRST   = 3'(BOARD_DIM - ROWS);

  logic dark;
  assign dark = x[0] ^ y[0];

  // Pieces sit only on dark squares: black men at the top rows, red men at the bottom.
  always_comb begin
    code = SQ_EMPTY;
    if (dark && (y < BLACK_LIMIT)) begin
      code = SQ_BLACK_MAN;
    end else if (dark && (y >= RED_FIRST)) begin
      code = SQ_RED_MAN;
    end
  end

endmodule

// File: rtl/board_state_ctrl.sv
// rtl/board_state_ctrl.sv - checkers board register file with command FSM, read port and piece counters
module board_state_ctrl
  import board_state_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       locX_state,
  input  logic [7:0]       locY_state,
  input  logic [7:0]       update_state,
  input  logic             wea_state_ram,
  input  logic [2:0]       rd_x,
  input  logic [2:0]       rd_y,
  output logic [2:0]       rd_state,
  output logic             busy,
  output logic             done,
  output logic             cmd_err,
  output logic [CNT_W-1:0] red_count,
  output logic [CNT_W-1:0] black_count
);

  logic [2:0]       cells [CELLS];
  state_t           state, state_next;
  logic [5:0]       sweep_idx;
  logic             wea_q;
  logic             strobe;
  logic             is_sweep_cmd;
  logic             write_ok;
  logic             wr_en;
  logic [5:0]       wr_idx;
  logic [2:0]       wr_data;
  logic [2:0]       old_code;
  logic             done_set;
  logic             err_set;
  logic             err_pend;
  logic             cnt_clear;
  logic [CNT_W-1:0] red_base, black_base;
  logic [2:0]       rom_code;

  // Level held high across reset release is not a command because wea_q resets high.
  assign strobe       = wea_state_ram & ~wea_q;
  assign is_sweep_cmd = (update_state == CMD_CLEAR) || (update_state == CMD_INIT);
  assign write_ok     = (locX_state < 8'd8) && (locY_state < 8'd8) &&
                        (update_state <= CMD_MAX_CODE);
  assign busy         = (state != ST_IDLE);

  board_init_rom #(.ROWS(INIT_ROWS)) u_init_rom (
    .x    (sweep_idx[2:0]),
    .y    (sweep_idx[5:3]),
    .code (rom_code)
  );

  // State register, sweep index and strobe edge register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      sweep_idx <= 6'd0;
      wea_q     <= 1'b1;
    end else begin
      state     <= state_next;
      sweep_idx <= (state == ST_IDLE) ? 6'd0 : sweep_idx + 6'd1;
      wea_q     <= wea_state_ram;
    end
  end

  // Next-state: sweeps start from IDLE and end after cell 63.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (strobe && (update_state == CMD_CLEAR)) begin
          state_next = ST_CLEAR;
        end else if (strobe && (update_state == CMD_INIT)) begin
          state_next = ST_INIT;
        end
      end
      ST_CLEAR, ST_INIT: begin
        if (sweep_idx == 6'd63) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs: write port, completion/error requests and counter deltas.
  always_comb begin
    wr_en     = 1'b0;
    wr_idx    = {locY_state[2:0], locX_state[2:0]};
    wr_data   = update_state[2:0];
    old_code  = cells[wr_idx];
    done_set  = 1'b0;
    err_set   = 1'b0;
    cnt_clear = 1'b0;
    case (state)
      ST_IDLE: begin
        if (strobe && !is_sweep_cmd) begin
          if (write_ok) begin
            wr_en    = 1'b1;
            done_set = 1'b1;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      ST_CLEAR, ST_INIT: begin
        wr_en     = 1'b1;
        wr_idx    = sweep_idx;
        wr_data   = (state == ST_INIT) ? rom_code : SQ_EMPTY;
        old_code  = SQ_EMPTY;
        cnt_clear = (sweep_idx == 6'd0);
        done_set  = (sweep_idx == 6'd63);
        err_set   = strobe;
      end
      default: ;
    endcase
    red_base   = cnt_clear ? '0 : red_count;
    black_base = cnt_clear ? '0 : black_count;
  end

  // Board storage: one write per cycle from either a command or the sweep.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CELLS; i++) begin
        cells[i] <= SQ_EMPTY;
      end
    end else if (wr_en) begin
      cells[wr_idx] <= wr_data;
    end
  end

  // Registered display read; sees the value before any same-cycle write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state <= SQ_EMPTY;
    end else begin
      rd_state <= cells[{rd_y, rd_x}];
    end
  end

  // Piece counters follow the old/new code of each write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      red_count   <= '0;
      black_count <= '0;
    end else if (wr_en) begin
      red_count   <= cnt_step(red_base,   is_red(old_code),   is_red(wr_data));
      black_count <= cnt_step(black_base, is_black(old_code), is_black(wr_data));
    end
  end

  // Status pulses; an error coinciding with sweep completion is delivered one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done     <= 1'b0;
      cmd_err  <= 1'b0;
      err_pend <= 1'b0;
    end else begin
      done     <= done_set;
      cmd_err  <= (err_set & ~done_set) | err_pend;
      err_pend <= err_set & done_set;
    end
  end

endmodule

// File: tb/tb_board_state_ctrl.sv
// tb/tb_board_state_ctrl.sv - randomized self-checking bench for board_state_ctrl
module tb_board_state_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] loc_x, loc_y, upd;
  logic       wea;
  logic [2:0] rd_x, rd_y;
  logic [2:0] rd_state;
  logic       busy, done, cmd_err;
  logic [6:0] red_count, black_count;

  int errors = 0;
  int checks = 0;
  int model [64];

  board_state_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .locX_state    (loc_x),
    .locY_state    (loc_y),
    .update_state  (upd),
    .wea_state_ram (wea),
    .rd_x          (rd_x),
    .rd_y          (rd_y),
    .rd_state      (rd_state),
    .busy          (busy),
    .done          (done),
    .cmd_err       (cmd_err),
    .red_count     (red_count),
    .black_count   (black_count)
  );

  always #5 clk = ~clk;

  function automatic int red_model();
    int n = 0;
    for (int i = 0; i < 64; i++) if (model[i] == 1 || model[i] == 3) n++;
    return n;
  endfunction

  function automatic int black_model();
    int n = 0;
    for (int i = 0; i < 64; i++) if (model[i] == 2 || model[i] == 4) n++;
    return n;
  endfunction

  function automatic int start_code(int x, int y);
    if ((x + y) % 2 == 1 && y < 3) return 2;
    if ((x + y) % 2 == 1 && y >= 5) return 1;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    checks++;
    if (done && cmd_err) begin
      errors++;
      $display("FAIL pulse_exclusive: done=%0b cmd_err=%0b required not both high", done, cmd_err);
    end
  endtask

  task automatic check_counts(string tag);
    checks++;
    if (red_count !== 7'(red_model())) begin
      errors++;
      $display("FAIL %s red_count: got %0d expected %0d", tag, red_count, red_model());
    end
    checks++;
    if (black_count !== 7'(black_model())) begin
      errors++;
      $display("FAIL %s black_count: got %0d expected %0d", tag, black_count, black_model());
    end
  endtask

  task automatic read_cell(int x, int y, string tag);
    rd_x = 3'(x);
    rd_y = 3'(y);
    tick();
    checks++;
    if (rd_state !== 3'(model[y * 8 + x])) begin
      errors++;
      $display("FAIL %s read(%0d,%0d): got %0d expected %0d", tag, x, y, rd_state, model[y * 8 + x]);
    end
  endtask

  task automatic check_board(string tag);
    for (int i = 0; i < 64; i++) read_cell(i % 8, i / 8, tag);
  endtask

  task automatic apply_write(int x, int y, int code, string tag);
    logic ok;
    ok = (x < 8) && (y < 8) && (code <= 4);
    loc_x = 8'(x);
    loc_y = 8'(y);
    upd   = 8'(code);
    wea   = 1'b1;
    tick();
    checks++;
    if (done !== ok || cmd_err !== !ok) begin
      errors++;
      $display("FAIL %s status: done=%0b cmd_err=%0b expected done=%0b cmd_err=%0b", tag, done, cmd_err, ok, !ok);
    end
    if (ok) model[y * 8 + x] = code;
    check_counts(tag);
    wea = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0 || cmd_err !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse_width: done=%0b cmd_err=%0b expected 0/0", tag, done, cmd_err);
    end
  endtask

  task automatic run_sweep(logic [7:0] cmd, int inject_at, string tag);
    int cnt;
    int err_cnt;
    upd = cmd;
    wea = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_start: got %0b expected 1", tag, busy);
    end
    cnt = busy ? 1 : 0;
    err_cnt = 0;
    for (int k = 0; k < 200 && busy; k++) begin
      if (k == inject_at) begin
        loc_x = 8'd0;
        loc_y = 8'd0;
        upd   = 8'd1;
        wea   = 1'b1;
      end else begin
        wea = 1'b0;
      end
      tick();
      if (cmd_err) err_cnt++;
      if (busy) cnt++;
      if (busy && done) begin
        errors++;
        $display("FAIL %s early_done: done=1 while busy, expected 0", tag);
      end
    end
    wea = 1'b0;
    checks++;
    if (cnt !== 64) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d expected 64", tag, cnt);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s done_end: got %0b expected 1", tag, done);
    end
    checks++;
    if (err_cnt !== ((inject_at >= 0) ? 1 : 0)) begin
      errors++;
      $display("FAIL %s err_pulses: got %0d expected %0d", tag, err_cnt, (inject_at >= 0) ? 1 : 0);
    end
    for (int i = 0; i < 64; i++) model[i] = (cmd == 8'hFF) ? 0 : start_code(i % 8, i / 8);
    check_counts(tag);
    tick();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 64; i++) model[i] = 0;
    loc_x = 0; loc_y = 0; upd = 8'd1; rd_x = 0; rd_y = 0;
    wea = 1'b1;
    reset = 1'b1;
    #12;
    checks++;
    if (busy !== 0 || done !== 0 || cmd_err !== 0 || rd_state !== 0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%0b done=%0b err=%0b rd=%0d expected all 0", busy, done, cmd_err, rd_state);
    end
    check_counts("reset");
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (done !== 0 || cmd_err !== 0) begin
        errors++;
        $display("FAIL reset_level_high: done=%0b err=%0b expected 0/0", done, cmd_err);
      end
    end
    check_counts("reset_level_high");
    wea = 1'b0;
    tick();
    apply_write(3, 2, 2, "first_cmd");
    read_cell(3, 2, "first_cmd");
  endtask

  task automatic test_single();
    apply_write(2, 5, 1, "red_man");
    read_cell(2, 5, "red_man");
    apply_write(2, 5, 4, "black_king");
    apply_write(2, 5, 4, "same_code");
    apply_write(2, 5, 0, "empty");
    read_cell(2, 5, "empty");
  endtask

  task automatic test_random(int n, string tag);
    int x, y, r, code;
    for (int i = 0; i < n; i++) begin
      x = $urandom_range(0, 9);
      y = $urandom_range(0, 9);
      r = $urandom_range(0, 9);
      code = (r < 8) ? (r % 5) : $urandom_range(5, 253);
      apply_write(x, y, code, tag);
      if (i % 4 == 3) read_cell($urandom_range(0, 7), $urandom_range(0, 7), tag);
    end
  endtask

  task automatic test_read_before_write();
    int old;
    old = model[4 * 8 + 4];
    rd_x = 3'd4;
    rd_y = 3'd4;
    tick();
    loc_x = 8'd4; loc_y = 8'd4; upd = 8'd3;
    wea = 1'b1;
    tick();
    checks++;
    if (rd_state !== 3'(old) || done !== 1'b1) begin
      errors++;
      $display("FAIL read_before_write: rd=%0d done=%0b expected rd=%0d done=1", rd_state, done, old);
    end
    model[4 * 8 + 4] = 3;
    wea = 1'b0;
    tick();
    checks++;
    if (rd_state !== 3'd3) begin
      errors++;
      $display("FAIL read_after_write: rd=%0d expected 3", rd_state);
    end
    check_counts("read_before_write");
  endtask

  task automatic test_errors();
    apply_write(8, 3, 1, "x_out_of_range");
    apply_write(3, 9, 2, "y_out_of_range");
    apply_write(2, 2, 7, "bad_code");
    check_board("after_errors");
  endtask

  task automatic test_reset_mid_sweep();
    upd = 8'hFE;
    wea = 1'b1;
    tick();
    wea = 1'b0;
    repeat (30) tick();
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 64; i++) model[i] = 0;
    checks++;
    if (busy !== 0 || done !== 0 || cmd_err !== 0) begin
      errors++;
      $display("FAIL reset_mid: busy=%0b done=%0b err=%0b expected 0/0/0", busy, done, cmd_err);
    end
    check_counts("reset_mid");
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 70; k++) begin
      tick();
      checks++;
      if (done !== 0 || busy !== 0) begin
        errors++;
        $display("FAIL reset_mid_after: done=%0b busy=%0b expected 0/0", done, busy);
      end
    end
    check_board("reset_mid");
  endtask

  initial begin
    test_reset();
    test_single();
    test_random(40, "random_a");
    test_read_before_write();
    run_sweep(8'hFE, 10, "init_inject");
    check_board("init");
    read_cell(1, 0, "init_1_0");
    read_cell(0, 7, "init_0_7");
    test_random(20, "random_b");
    run_sweep(8'hFE, -1, "init_again");
    run_sweep(8'hFF, 20, "clear");
    check_board("clear");
    test_random(12, "random_c");
    test_errors();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
